// File: rtl/sdram_ring_sequencer_pkg.sv
// Shared types and constants for the SDRAM ring-buffer sequencer.
package sdram_ring_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic OFF = 1'b0;
    localparam logic ON  = 1'b1;

    localparam int unsigned BURST_LOG2_DEF = 8;
    localparam int unsigned BURST          = 1 << BURST_LOG2_DEF;

    function automatic int unsigned burst_words(input int unsigned log2);
        return 1 << log2;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/sdram_ring_sequencer_if.sv
// Sequencer-side bundle: FIFO fill levels, burst command handshake and ring status.
interface sdram_ring_sequencer_if #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned FIFO_AW = 10
);
    logic               flush;
    logic [FIFO_AW-1:0] in_usedw;
    logic [FIFO_AW-1:0] out_usedw;
    logic               cmd_ready;
    logic               cmd_done;
    logic               cmd_valid;
    logic               cmd_write;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [ADDR_W:0]    level;
    logic               ring_full;
    logic               ring_empty;
    logic               overflow;

    modport master (
        input  flush, in_usedw, out_usedw, cmd_ready, cmd_done,
        output cmd_valid, cmd_write, cmd_addr, level, ring_full, ring_empty, overflow
    );

    modport slave (
        output flush, in_usedw, out_usedw, cmd_ready, cmd_done,
        input  cmd_valid, cmd_write, cmd_addr, level, ring_full, ring_empty, overflow
    );
endinterface

// File: rtl/sdram_ring_sequencer_ring_ptr_tracker.sv
// Ring write/read pointers in burst units with an extra wrap bit; registered level and full/empty.
module ring_ptr_tracker
    import sdram_ring_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned BURST_LOG2 = BURST_LOG2_DEF
) (
    input  logic              CLK48M,
    input  logic              RESET,
    input  logic              advance_wr,
    input  logic              advance_rd,
    input  logic              clear,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   level,
    output logic              ring_full,
    output logic              ring_empty
);
    localparam int unsigned     PW         = ADDR_W - BURST_LOG2 + 1;
    localparam int unsigned     LW         = ADDR_W + 1;
    localparam logic [ADDR_W:0] BURST_W    = LW'(burst_words(BURST_LOG2));
    localparam logic [ADDR_W:0] RING_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] FULL_LIM   = RING_WORDS - BURST_W;

    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0] level_next;

    // Pointer difference modulo 2^PW; the wrap bit keeps full distinct from empty.
    always_comb begin
        level_next = {wr_ptr - rd_ptr, {BURST_LOG2{1'b0}}};
        wr_addr    = {wr_ptr[PW-2:0], {BURST_LOG2{1'b0}}};
        rd_addr    = {rd_ptr[PW-2:0], {BURST_LOG2{1'b0}}};
    end

    always_ff @(posedge CLK48M or negedge RESET) begin
        if (!RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            ring_full  <= OFF;
            ring_empty <= ON;
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (advance_wr) wr_ptr <= wr_ptr + PW'(1);
                if (advance_rd) rd_ptr <= rd_ptr + PW'(1);
            end
            level      <= level_next;
            ring_full  <= (level_next > FULL_LIM);
            ring_empty <= (level_next < BURST_W);
        end
    end
endmodule

// File: rtl/sdram_ring_sequencer.sv
// Burst arbiter between the FIFOs and the SDRAM controller, treating SDRAM as a circular buffer.
module sdram_ring_sequencer
    import sdram_ring_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned BURST_LOG2 = 8,
    parameter int unsigned FIFO_AW    = 10
) (
    input  logic                  CLK48M,
    input  logic                  RESET,
    sdram_ring_sequencer_if.master bus
);
    localparam int unsigned      FW       = FIFO_AW + 1;
    localparam logic [FIFO_AW:0] BURST_F  = FW'(burst_words(BURST_LOG2));
    localparam logic [FIFO_AW-1:0] FIFO_MAX = FIFO_AW'(fifo_depth(FIFO_AW) - 1);

    state_t            state, state_n;
    logic              valid_q, valid_n, write_q, write_n;
    logic [ADDR_W-1:0] addr_q, addr_n, wr_addr, rd_addr;
    logic              last_was_wr, last_n, flush_pend, settle, overflow_q;
    logic              adv_wr, adv_rd, do_flush, pick_wr, wr_ok, rd_ok;
    logic [FIFO_AW-1:0] free_words;
    logic [ADDR_W:0]   level_w;
    logic              full_w, empty_w;

    ring_ptr_tracker #(
        .ADDR_W     (ADDR_W),
        .BURST_LOG2 (BURST_LOG2)
    ) u_ptr (
        .CLK48M     (CLK48M),
        .RESET      (RESET),
        .advance_wr (adv_wr),
        .advance_rd (adv_rd),
        .clear      (do_flush),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .level      (level_w),
        .ring_full  (full_w),
        .ring_empty (empty_w)
    );

    always_comb begin
        free_words = FIFO_MAX - bus.out_usedw;
        wr_ok      = ({1'b0, bus.in_usedw} >= BURST_F) && !full_w;
        rd_ok      = !empty_w && ({1'b0, free_words} >= BURST_F);
    end

    always_comb begin
        state_n  = state;
        valid_n  = valid_q;
        write_n  = write_q;
        addr_n   = addr_q;
        last_n   = last_was_wr;
        adv_wr   = OFF;
        adv_rd   = OFF;
        do_flush = OFF;
        pick_wr  = OFF;
        unique case (state)
            IDLE: begin
                // settle skips the cycle where level/full/empty still lag a pointer change.
                if (bus.flush || flush_pend) begin
                    do_flush = ON;
                end else if (!settle && (wr_ok || rd_ok)) begin
                    pick_wr = wr_ok && (!rd_ok || !last_was_wr);
                    state_n = ISSUE;
                    valid_n = ON;
                    write_n = pick_wr;
                    addr_n  = pick_wr ? wr_addr : rd_addr;
                end
            end
            ISSUE: begin
                if (bus.cmd_ready) begin
                    valid_n = OFF;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (bus.cmd_done) begin
                    adv_wr  = write_q;
                    adv_rd  = !write_q;
                    last_n  = write_q;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK48M or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            valid_q     <= OFF;
            write_q     <= OFF;
            addr_q      <= '0;
            last_was_wr <= OFF;
            flush_pend  <= OFF;
            settle      <= OFF;
            overflow_q  <= OFF;
        end else begin
            state       <= state_n;
            valid_q     <= valid_n;
            write_q     <= write_n;
            addr_q      <= addr_n;
            last_was_wr <= last_n;
            settle      <= adv_wr || adv_rd || do_flush;
            if (do_flush)                      flush_pend <= OFF;
            else if (bus.flush && state != IDLE) flush_pend <= ON;
            if (do_flush)                                    overflow_q <= OFF;
            else if (full_w && bus.in_usedw == FIFO_MAX)     overflow_q <= ON;
        end
    end

    assign bus.cmd_valid  = valid_q;
    assign bus.cmd_write  = write_q;
    assign bus.cmd_addr   = addr_q;
    assign bus.level      = level_w;
    assign bus.ring_full  = full_w;
    assign bus.ring_empty = empty_w;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_sdram_ring_sequencer.sv
// Scoreboard bench for sdram_ring_sequencer on a 1024-word ring with 256-word bursts.
module tb_sdram_ring_sequencer;
    localparam int unsigned AW  = 10;
    localparam int unsigned FAW = 10;

    logic CLK48M = 1'b0;
    logic RESET  = 1'b0;
    always #10 CLK48M = ~CLK48M;

    sdram_ring_sequencer_if #(.ADDR_W(AW), .FIFO_AW(FAW)) bus ();

    sdram_ring_sequencer #(
        .ADDR_W     (AW),
        .BURST_LOG2 (8),
        .FIFO_AW    (FAW)
    ) dut (
        .CLK48M (CLK48M),
        .RESET  (RESET),
        .bus    (bus)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Every presented command is compared to the head of the queue; popped on handshake.
    always @(negedge CLK48M) begin
        if (RESET && bus.cmd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd actual=write:%0d addr:%0d expected=none",
                         bus.cmd_write, bus.cmd_addr);
            end else begin
                chk("cmd_write", 32'(bus.cmd_write), 32'(exp_q[0].wr));
                chk("cmd_addr", 32'(bus.cmd_addr), 32'(exp_q[0].addr));
                if (bus.cmd_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK48M);
        #1;
    endtask

    task automatic quiet();
        bus.in_usedw  = '0;
        bus.out_usedw = '1;
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input int bound, input int hold);
        cmd_t c;
        int   n = 0;
        c.wr   = w;
        c.addr = a;
        exp_q.push_back(c);
        while (!bus.cmd_valid && n < bound) begin
            tick(1);
            n++;
        end
        chk("cmd_valid_seen", 32'(bus.cmd_valid), 32'd1);
        if (!bus.cmd_valid) begin
            exp_q.delete();
            quiet();
            return;
        end
        if (hold > 0) begin
            tick(hold);
            chk("cmd_valid_held", 32'(bus.cmd_valid), 32'd1);
        end
        bus.cmd_ready = 1'b1;
        tick(1);
        bus.cmd_ready = 1'b0;
        quiet();
    endtask

    task automatic finish_done(input int lat);
        tick(lat);
        bus.cmd_done = 1'b1;
        tick(1);
        bus.cmd_done = 1'b0;
    endtask

    task automatic burst(input logic w, input logic [AW-1:0] a, input int hold);
        issue(w, a, 8, hold);
        finish_done(3);
    endtask

    task automatic set_fifo(input int in_w, input int out_w);
        bus.in_usedw  = FAW'(in_w);
        bus.out_usedw = FAW'(out_w);
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.cmd_done  = 1'b0;
        quiet();
        tick(2);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_cmd_write", 32'(bus.cmd_write), 32'd0);
        chk("rst_cmd_addr", 32'(bus.cmd_addr), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_full", 32'(bus.ring_full), 32'd0);
        chk("rst_empty", 32'(bus.ring_empty), 32'd1);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        RESET = 1'b1;
        tick(1);

        // First write burst, command visible within 2 cycles
        set_fifo(256, 0);
        issue(1'b1, 10'd0, 2, 0);
        finish_done(3);
        tick(2);
        chk("w1_level", 32'(bus.level), 32'd256);
        chk("w1_empty", 32'(bus.ring_empty), 32'd0);

        // cmd_done outside WAIT is ignored
        bus.cmd_done = 1'b1;
        tick(1);
        bus.cmd_done = 1'b0;
        tick(3);
        chk("stray_done_level", 32'(bus.level), 32'd256);

        set_fifo(256, 1023);
        burst(1'b1, 10'd256, 0);
        tick(2);
        chk("w2_level", 32'(bus.level), 32'd512);

        // Both eligible: after a write, read wins; then write wins
        set_fifo(300, 0);
        burst(1'b0, 10'd0, 0);
        tick(2);
        chk("rr_read_level", 32'(bus.level), 32'd256);
        set_fifo(300, 0);
        burst(1'b1, 10'd512, 10);
        tick(2);
        chk("rr_write_level", 32'(bus.level), 32'd512);

        // Flush in IDLE
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        tick(2);
        chk("flush_idle_level", 32'(bus.level), 32'd0);
        chk("flush_idle_empty", 32'(bus.ring_empty), 32'd1);

        // Fill the ring completely
        for (int i = 0; i < 4; i++) begin
            set_fifo(256, 1023);
            burst(1'b1, AW'(i * 256), 0);
        end
        set_fifo(256, 1023);
        tick(5);
        chk("full_level", 32'(bus.level), 32'd1024);
        chk("full_flag", 32'(bus.ring_full), 32'd1);
        chk("full_no_write", 32'(bus.cmd_valid), 32'd0);
        set_fifo(1023, 1023);
        tick(2);
        chk("overflow_set", 32'(bus.overflow), 32'd1);
        set_fifo(1023, 0);
        burst(1'b0, 10'd0, 0);
        tick(2);
        chk("drain_level", 32'(bus.level), 32'd768);
        chk("drain_full", 32'(bus.ring_full), 32'd0);
        chk("overflow_sticky", 32'(bus.overflow), 32'd1);
        set_fifo(256, 1023);
        burst(1'b1, 10'd0, 0);
        tick(2);
        chk("wrap_level", 32'(bus.level), 32'd1024);

        // Flush during WAIT is deferred until the burst completes
        set_fifo(0, 0);
        issue(1'b0, 10'd256, 8, 0);
        tick(1);
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        chk("flush_wait_level", 32'(bus.level), 32'd1024);
        chk("flush_wait_ovf", 32'(bus.overflow), 32'd1);
        finish_done(2);
        tick(3);
        chk("flush_done_level", 32'(bus.level), 32'd0);
        chk("flush_done_empty", 32'(bus.ring_empty), 32'd1);
        chk("flush_done_full", 32'(bus.ring_full), 32'd0);
        chk("flush_done_ovf", 32'(bus.overflow), 32'd0);

        // Read gated by output FIFO free space
        set_fifo(256, 1023);
        burst(1'b1, 10'd0, 0);
        set_fifo(0, 800);
        tick(6);
        chk("no_room_no_read", 32'(bus.cmd_valid), 32'd0);
        chk("no_room_level", 32'(bus.level), 32'd256);
        set_fifo(0, 767);
        burst(1'b0, 10'd0, 0);
        tick(2);
        chk("room_read_level", 32'(bus.level), 32'd0);

        // Asynchronous reset in the middle of WAIT
        set_fifo(256, 1023);
        burst(1'b1, 10'd256, 0);
        set_fifo(256, 1023);
        issue(1'b1, 10'd512, 8, 0);
        chk("pre_rst_level", 32'(bus.level), 32'd256);
        #3;
        RESET = 1'b0;
        #1;
        chk("arst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("arst_cmd_write", 32'(bus.cmd_write), 32'd0);
        chk("arst_cmd_addr", 32'(bus.cmd_addr), 32'd0);
        chk("arst_level", 32'(bus.level), 32'd0);
        chk("arst_empty", 32'(bus.ring_empty), 32'd1);
        tick(2);
        RESET = 1'b1;
        tick(2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
